// File: rtl/aes_round_tail.sv
// AES-128 round tail: ShiftRows, MixColumns (skipped on the final round) and AddRoundKey
// behind a two-stage valid/ready pipeline that follows the registered SubBytes stage.
module aes_round_tail #(
   parameter int NUM_ROUNDS = 10,
   parameter int TAG_W      = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [127:0]     in_state_i,
   input  logic [127:0]     round_key_i,
   input  logic [TAG_W-1:0] round_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [127:0]     out_state_o,
   output logic [TAG_W-1:0] round_o
);

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // byte (r + 4c) is row r of column c
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] res;
      res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            res[8*(row+4*c) +: 8] = s[8*(row+4*((c+row)%4)) +: 8];
         end
      end
      return res;
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      logic [31:0] res;
      a0 = col[7:0];
      a1 = col[15:8];
      a2 = col[23:16];
      a3 = col[31:24];
      res[7:0]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      res[15:8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      res[23:16] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      res[31:24] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      return res;
   endfunction

   logic             v1, v2;
   logic             adv1, adv2;
   logic [127:0]     s1_data, s1_key, s2_data;
   logic [TAG_W-1:0] s1_tag, s2_tag;
   logic [127:0]     sr, mc, s1_next;

   always_comb begin
      sr = shift_rows(in_state_i);
      for (int c = 0; c < 4; c++) begin
         mc[32*c +: 32] = mix_column(sr[32*c +: 32]);
      end
      s1_next = (round_i == TAG_W'(NUM_ROUNDS)) ? sr : mc;
   end

   // in_ready_o looks through to out_ready_i so a full pipe can accept while draining
   always_comb begin
      adv2       = v1 && (!v2 || out_ready_i);
      in_ready_o = !v1 || adv2;
      adv1       = in_valid_i && in_ready_o;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         s1_data <= '0;
         s1_key  <= '0;
         s1_tag  <= '0;
         s2_data <= '0;
         s2_tag  <= '0;
      end else begin
         v2 <= adv2 ? 1'b1 : (out_ready_i ? 1'b0 : v2);
         v1 <= adv1 ? 1'b1 : (adv2 ? 1'b0 : v1);
         if (adv1) begin
            s1_data <= s1_next;
            s1_key  <= round_key_i;
            s1_tag  <= round_i;
         end
         if (adv2) begin
            s2_data <= s1_data ^ s1_key;
            s2_tag  <= s1_tag;
         end
      end
   end

   assign out_valid_o = v2;
   assign out_state_o = s2_data;
   assign round_o     = s2_tag;

endmodule

// File: tb/tb_aes_round_tail.sv
// Self-checking bench for aes_round_tail: known-answer table, throughput,
// backpressure and mid-flight reset, with a scoreboard queue on the output.
module tb_aes_round_tail;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         in_valid_i;
   logic         in_ready_o;
   logic [127:0] in_state_i;
   logic [127:0] round_key_i;
   logic [3:0]   round_i;
   logic         out_valid_o;
   logic         out_ready_i;
   logic [127:0] out_state_o;
   logic [3:0]   round_o;

   aes_round_tail #(.NUM_ROUNDS(10), .TAG_W(4)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_state_i  (in_state_i),
      .round_key_i (round_key_i),
      .round_i     (round_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_state_o (out_state_o),
      .round_o     (round_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [127:0] st;
      logic [127:0] key;
      logic [3:0]   rnd;
      logic [127:0] exp;
   } vec_t;

   typedef struct {
      logic [127:0] d;
      logic [3:0]   r;
   } exp_t;

   localparam int NV = 11;
   vec_t vt[NV];
   exp_t sb[$];
   exp_t cur_exp;
   exp_t got_exp;
   int   n_vec = 0;
   int   n_err = 0;

   // literals are written byte 0 first; the DUT wants byte 0 in bits [7:0]
   function automatic logic [127:0] bl(input logic [127:0] x);
      logic [127:0] r;
      for (int n = 0; n < 16; n++) r[8*n +: 8] = x[127-8*n -: 8];
      return r;
   endfunction

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_beat(input int i);
      in_valid_i  = 1'b1;
      in_state_i  = vt[i].st;
      round_key_i = vt[i].key;
      round_i     = vt[i].rnd;
      cur_exp     = '{d: vt[i].exp, r: vt[i].rnd};
   endtask

   task automatic idle();
      in_valid_i  = 1'b0;
      in_state_i  = {$urandom, $urandom, $urandom, $urandom};
      round_key_i = {$urandom, $urandom, $urandom, $urandom};
      round_i     = 4'($urandom_range(0, 15));
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 40 && (sb.size() != 0 || out_valid_o); k++) step();
      check("drain_left", 128'(sb.size()), 128'd0);
   endtask

   // scoreboard: pop on output handshake, push on input handshake
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (out_valid_o && out_ready_i) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_out: got %h tag %0d, required no beat", out_state_o, round_o);
            end else begin
               got_exp = sb.pop_front();
               if (out_state_o !== got_exp.d || round_o !== got_exp.r) begin
                  n_err++;
                  $display("FAIL out_beat: got %h tag %0d required %h tag %0d",
                           out_state_o, round_o, got_exp.d, got_exp.r);
               end
            end
         end
         if (in_valid_i && in_ready_o) sb.push_back(cur_exp);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   j;
      logic acc;
      logic [127:0] held;

      vt[0]  = '{bl(128'hd42711aee0bf98f1b8b45de51e415230), bl(128'ha0fafe1788542cb123a339392a6c7605),
                 4'd1, bl(128'ha49c7ff2689f352b6b5bea43026a5049)};
      vt[1]  = '{bl({4{32'hdb135345}}), '0, 4'd1, bl({4{32'h8e4da1bc}})};
      vt[2]  = '{bl(128'h000102030405060708090a0b0c0d0e0f), '0, 4'd10,
                 bl(128'h00050a0f04090e03080d02070c01060b)};
      vt[3]  = '{bl({4{32'hf20a225c}}), '0, 4'd1, bl({4{32'h9fdc589d}})};
      vt[4]  = '{bl({4{32'h2d26314c}}), '0, 4'd2, bl({4{32'h4d7ebdf8}})};
      vt[5]  = '{bl({4{32'hc6c6c6c6}}), '0, 4'd3, bl({4{32'hc6c6c6c6}})};
      vt[6]  = '{bl({4{32'hd4d4d4d5}}), '0, 4'd9, bl({4{32'hd5d5d7d6}})};
      vt[7]  = '{bl({4{32'hdb135345}}), '0, 4'd10, bl({4{32'hdb135345}})};
      vt[8]  = '{'0, bl(128'ha0fafe1788542cb123a339392a6c7605), 4'd5,
                 bl(128'ha0fafe1788542cb123a339392a6c7605)};
      vt[9]  = '{bl(128'h000102030405060708090a0b0c0d0e0f), {128{1'b1}}, 4'd10,
                 bl(128'hfffaf5f0fbf6f1fcf7f2fdf8f3fef9f4)};
      vt[10] = '{bl({4{32'hdb135345}}), '0, 4'd15, bl({4{32'h8e4da1bc}})};

      rst_i = 1'b1;
      out_ready_i = 1'b1;
      cur_exp = '{d: '0, r: '0};
      idle();
      step();
      step();
      rst_i = 1'b0;
      check("rst_out_valid", 128'(out_valid_o), 128'd0);
      check("rst_out_state", out_state_o, 128'd0);
      check("rst_round", 128'(round_o), 128'd0);
      check("rst_in_ready", 128'(in_ready_o), 128'd1);

      // known-answer table, one beat at a time, with latency checks
      for (int i = 0; i < NV; i++) begin
         set_beat(i);
         check("kat_in_ready", 128'(in_ready_o), 128'd1);
         step();
         idle();
         check("kat_lat1_valid", 128'(out_valid_o), 128'd0);
         step();
         check("kat_lat2_valid", 128'(out_valid_o), 128'd1);
         step();
      end

      // back-to-back beats: outputs on cycles 2..9
      for (int k = 0; k < 8; k++) begin
         set_beat(k);
         check("tput_in_ready", 128'(in_ready_o), 128'd1);
         check("tput_out_valid", 128'(out_valid_o), 128'(k >= 2));
         step();
      end
      idle();
      check("tput_out_valid_c8", 128'(out_valid_o), 128'd1);
      step();
      check("tput_out_valid_c9", 128'(out_valid_o), 128'd1);
      step();
      check("tput_out_valid_c10", 128'(out_valid_o), 128'd0);
      wait_drain();

      // backpressure: only two beats fit while the consumer stalls
      out_ready_i = 1'b0;
      j = 0;
      held = '0;
      for (int c = 0; c < 5; c++) begin
         if (j < 4) set_beat(3 + j);
         check("bp_in_ready", 128'(in_ready_o), 128'(c < 2));
         if (c == 2) begin
            check("bp_out_valid", 128'(out_valid_o), 128'd1);
            held = out_state_o;
         end
         if (c > 2) check("bp_hold", out_state_o, held);
         acc = in_ready_o;
         step();
         if (acc) j++;
      end
      check("bp_accepted", 128'(j), 128'd2);
      out_ready_i = 1'b1;
      for (int k = 0; k < 20 && j < 4; k++) begin
         set_beat(3 + j);
         acc = in_ready_o;
         step();
         if (acc) j++;
      end
      idle();
      wait_drain();

      // reset with both stages full
      out_ready_i = 1'b0;
      set_beat(0);
      step();
      set_beat(1);
      step();
      idle();
      check("pre_rst_valid", 128'(out_valid_o), 128'd1);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      sb.delete();
      check("mid_rst_out_valid", 128'(out_valid_o), 128'd0);
      check("mid_rst_out_state", out_state_o, 128'd0);
      check("mid_rst_round", 128'(round_o), 128'd0);
      check("mid_rst_in_ready", 128'(in_ready_o), 128'd1);
      out_ready_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check("post_rst_no_beat", 128'(out_valid_o), 128'd0);
         step();
      end
      set_beat(2);
      step();
      idle();
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
